// File: rtl/soc_pio_pkg.sv
// Shared address map, edge-type encodings and bus payload type for the
// edge-capturing Avalon-MM input PIO.
package soc_pio_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // One slave access as seen in a single clock
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [BUS_W-1:0]  wdata;
  } pio_bus_t;

  function automatic logic is_write(input logic chipselect, input logic write_n);
    return chipselect & ~write_n;
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input bus plus per-bit edge
// detection (rise / fall / any) against the previous synchronised sample.
module pio_sync_edge
  import soc_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           EDGE_TYPE   = EDGE_RISE,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_port_i,
  output logic [DATA_WIDTH-1:0] sync_q_o,
  output logic [DATA_WIDTH-1:0] edge_det_c_o
);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] chain_q;
  logic [DATA_WIDTH-1:0]                  prev_q;
  logic [DATA_WIDTH-1:0]                  sync_c;
  logic [DATA_WIDTH-1:0]                  rise_c;
  logic [DATA_WIDTH-1:0]                  fall_c;

  // Reset value seeds both sync and prev so no edge appears at reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= {SYNC_STAGES{RESET_VALUE}};
      prev_q  <= RESET_VALUE;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], in_port_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_c   = chain_q[SYNC_STAGES-1];
  assign sync_q_o = sync_c;
  assign rise_c   = sync_c & ~prev_q;
  assign fall_c   = ~sync_c & prev_q;

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_det_c_o = fall_c;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_det_c_o = rise_c | fall_c;
    end else begin : g_rise
      assign edge_det_c_o = rise_c;
    end
  endgenerate

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO with sticky edge capture and maskable level irq.
// Optional macro PIO_BIT_CLEAR_EN: edgecapture writes become write-1-to-clear.
module soc_system_pio_in_edge
  import soc_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           EDGE_TYPE   = EDGE_RISE,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [BUS_W-1:0]      writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [BUS_W-1:0]      readdata,
  output logic                  irq
);

  pio_bus_t              bus_c;
  logic [DATA_WIDTH-1:0] sync_c;
  logic [DATA_WIDTH-1:0] edge_det_c;
  logic [DATA_WIDTH-1:0] clr_c;

  logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [BUS_W-1:0]      readdata_q, readdata_d;
  logic                  irq_q, irq_d;
  logic                  unused_wdata;

  assign bus_c.addr  = address;
  assign bus_c.wr    = is_write(chipselect, write_n);
  assign bus_c.wdata = writedata;
  assign unused_wdata = ^bus_c.wdata;

  pio_sync_edge #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync_edge (
    .clk          (clk),
    .reset        (reset),
    .in_port_i    (in_port),
    .sync_q_o     (sync_c),
    .edge_det_c_o (edge_det_c)
  );

  // Register next-state: clear mask, sticky capture (set wins), mask, irq, read mux
  always_comb begin
    clr_c      = '0;
    irqmask_d  = irqmask_q;
    readdata_d = '0;

    if (bus_c.wr && bus_c.addr == ADDR_EDGECAP) begin
`ifdef PIO_BIT_CLEAR_EN
      clr_c = bus_c.wdata[DATA_WIDTH-1:0];
`else
      clr_c = '1;
`endif
    end

    if (bus_c.wr && bus_c.addr == ADDR_IRQMASK) begin
      irqmask_d = bus_c.wdata[DATA_WIDTH-1:0];
    end

    edgecap_d = (edgecap_q & ~clr_c) | edge_det_c;
    irq_d     = |(edgecap_q & irqmask_q);

    case (bus_c.addr)
      ADDR_DATA:    readdata_d = BUS_W'(sync_c);
      ADDR_RSVD:    readdata_d = '0;
      ADDR_IRQMASK: readdata_d = BUS_W'(irqmask_q);
      ADDR_EDGECAP: readdata_d = BUS_W'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Bench for soc_system_pio_in_edge: directed table, hand sequences on an
// 8-bit rising-edge instance and a 32-bit any-edge instance, random vs model.
module tb_soc_system_pio_in_edge;

  localparam int unsigned S_A = 2;
  localparam int unsigned S_B = 3;
`ifdef PIO_BIT_CLEAR_EN
  localparam logic [31:0] AFTER_CLR = 32'h0000_0080;
`else
  localparam logic [31:0] AFTER_CLR = 32'h0000_0000;
`endif

  logic        clk;
  logic        reset;

  logic [1:0]  address_a, address_b;
  logic        cs_a, cs_b, write_n_a, write_n_b;
  logic [31:0] wdata_a, wdata_b;
  logic [7:0]  in_a;
  logic [31:0] in_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int n_vec;
  int n_err;

  soc_system_pio_in_edge #(
    .DATA_WIDTH(8), .SYNC_STAGES(S_A), .EDGE_TYPE(0), .RESET_VALUE(8'h00)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address_a), .chipselect(cs_a),
    .write_n(write_n_a), .writedata(wdata_a), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  soc_system_pio_in_edge #(
    .DATA_WIDTH(32), .SYNC_STAGES(S_B), .EDGE_TYPE(2), .RESET_VALUE(32'h0)
  ) dut_b (
    .clk(clk), .reset(reset), .address(address_b), .chipselect(cs_b),
    .write_n(write_n_b), .writedata(wdata_b), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  inp;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic [1:0] a, input logic w, input logic [31:0] wd,
                              input logic [7:0] ip, input logic [31:0] er, input logic ei);
    vec_t v;
    v.addr = a; v.wr = w; v.wdata = wd; v.inp = ip; v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is at a falling edge; drive, let one rising edge pass, return at the next fall
  task automatic step_a(input logic cs, input logic [1:0] a, input logic w,
                        input logic [31:0] wd, input logic [7:0] ip);
    cs_a = cs; address_a = a; write_n_a = ~w; wdata_a = wd; in_a = ip;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_b(input logic [1:0] a, input logic w, input logic [31:0] wd,
                        input logic [31:0] ip);
    cs_b = 1'b1; address_b = a; write_n_b = ~w; wdata_b = wd; in_b = ip;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cs_a = 1'b0; address_a = '0; write_n_a = 1'b1; wdata_a = '0; in_a = '0;
    cs_b = 1'b0; address_b = '0; write_n_b = 1'b1; wdata_b = '0; in_b = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model for instance A: the synchronised value is simply the input
  // as it stood S_A clocks earlier; registers follow the register-map rules.
  logic [7:0]  m_hist[$];
  logic [7:0]  m_cap, m_mask;
  logic [31:0] m_rd;
  logic        m_irq;

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i <= int'(S_A); i++) m_hist.push_back(8'h00);
    m_cap = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
  endtask

  task automatic model_step(input logic wr_eff, input logic [1:0] a,
                            input logic [31:0] wd, input logic [7:0] ip);
    logic [7:0] now_v, before_v, clr;
    now_v    = m_hist[$-(S_A-1)];
    before_v = m_hist[$-S_A];
    case (a)
      2'd0:    m_rd = {24'h0, now_v};
      2'd2:    m_rd = {24'h0, m_mask};
      2'd3:    m_rd = {24'h0, m_cap};
      default: m_rd = 32'h0;
    endcase
    m_irq = (m_cap & m_mask) != 8'h00;
    clr = 8'h00;
    if (wr_eff && a == 2'd3) begin
`ifdef PIO_BIT_CLEAR_EN
      clr = wd[7:0];
`else
      clr = 8'hFF;
`endif
    end
    m_cap = (m_cap & ~clr) | (now_v & ~before_v);
    if (wr_eff && a == 2'd2) m_mask = wd[7:0];
    m_hist.push_back(ip);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    tbl[0]  = mk(2'd3, 1'b0, 32'h0,        8'h81, 32'h00,    1'b0);
    tbl[1]  = mk(2'd3, 1'b0, 32'h0,        8'h81, 32'h00,    1'b0);
    tbl[2]  = mk(2'd3, 1'b0, 32'h0,        8'h81, 32'h00,    1'b0);
    tbl[3]  = mk(2'd3, 1'b0, 32'h0,        8'h81, 32'h81,    1'b0);
    tbl[4]  = mk(2'd0, 1'b0, 32'h0,        8'h81, 32'h81,    1'b0);
    tbl[5]  = mk(2'd2, 1'b1, 32'hFFFFFF01, 8'h81, 32'h00,    1'b0);
    tbl[6]  = mk(2'd2, 1'b0, 32'h0,        8'h81, 32'h01,    1'b1);
    tbl[7]  = mk(2'd3, 1'b1, 32'h01,       8'h81, 32'h81,    1'b1);
    tbl[8]  = mk(2'd3, 1'b0, 32'h0,        8'h81, AFTER_CLR, 1'b0);
    tbl[9]  = mk(2'd3, 1'b0, 32'h0,        8'h00, AFTER_CLR, 1'b0);
    tbl[10] = mk(2'd3, 1'b0, 32'h0,        8'h00, AFTER_CLR, 1'b0);
    tbl[11] = mk(2'd3, 1'b0, 32'h0,        8'h00, AFTER_CLR, 1'b0);
    tbl[12] = mk(2'd3, 1'b0, 32'h0,        8'h00, AFTER_CLR, 1'b0);
    tbl[13] = mk(2'd0, 1'b1, 32'hFF,       8'h00, 32'h00,    1'b0);
    tbl[14] = mk(2'd1, 1'b0, 32'h0,        8'h00, 32'h00,    1'b0);
    tbl[15] = mk(2'd2, 1'b0, 32'h0,        8'h00, 32'h01,    1'b0);
    tbl[16] = mk(2'd2, 1'b1, 32'h08,       8'h00, 32'h01,    1'b0);
    tbl[17] = mk(2'd3, 1'b0, 32'h0,        8'h08, AFTER_CLR, 1'b0);
    tbl[18] = mk(2'd3, 1'b0, 32'h0,        8'h08, AFTER_CLR, 1'b0);
    tbl[19] = mk(2'd3, 1'b1, 32'hFF,       8'h08, AFTER_CLR, 1'b0);
    tbl[20] = mk(2'd3, 1'b0, 32'h0,        8'h08, 32'h08,    1'b1);
    tbl[21] = mk(2'd2, 1'b0, 32'h0,        8'h08, 32'h08,    1'b1);
    tbl[22] = mk(2'd3, 1'b0, 32'h0,        8'h00, 32'h08,    1'b1);
    tbl[23] = mk(2'd3, 1'b0, 32'h0,        8'h08, 32'h08,    1'b1);
    tbl[24] = mk(2'd3, 1'b0, 32'h0,        8'h08, 32'h08,    1'b1);
    tbl[25] = mk(2'd3, 1'b1, 32'hFF,       8'h08, 32'h08,    1'b1);
    tbl[26] = mk(2'd3, 1'b0, 32'h0,        8'h08, 32'h08,    1'b1);
    tbl[27] = mk(2'd3, 1'b1, 32'hFF,       8'h08, 32'h08,    1'b1);
    tbl[28] = mk(2'd3, 1'b0, 32'h0,        8'h08, 32'h00,    1'b0);

    // Reset values, then every address reads zero
    reset = 1'b1;
    do_reset();
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_irq_a", {31'h0, irq_a}, 32'h0);
    check("rst_rd_b", rd_b, 32'h0);
    for (int a = 0; a < 4; a++) begin
      step_a(1'b1, 2'(a), 1'b0, 32'h0, 8'h00);
      check($sformatf("rst_addr%0d", a), rd_a, 32'h0);
      check($sformatf("rst_addr%0d_irq", a), {31'h0, irq_a}, 32'h0);
    end

    // Directed register-map table
    do_reset();
    for (int i = 0; i < 29; i++) begin
      step_a(1'b1, tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].inp);
      check($sformatf("tbl%0d_rd", i), rd_a, tbl[i].exp_rd);
      check($sformatf("tbl%0d_irq", i), {31'h0, irq_a}, {31'h0, tbl[i].exp_irq});
    end

    // Asynchronous reset while edgecapture holds 0x05
    do_reset();
    step_a(1'b1, 2'd2, 1'b1, 32'h05, 8'h05);
    for (int i = 0; i < 5; i++) step_a(1'b1, 2'd3, 1'b0, 32'h0, 8'h05);
    check("midrst_pre_rd", rd_a, 32'h05);
    check("midrst_pre_irq", {31'h0, irq_a}, 32'h1);
    #2 reset = 1'b1;
    in_a = 8'h00;
    #1;
    check("midrst_async_rd", rd_a, 32'h0);
    check("midrst_async_irq", {31'h0, irq_a}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step_a(1'b1, 2'd3, 1'b0, 32'h0, 8'h00);
    check("midrst_post_cap", rd_a, 32'h0);
    step_a(1'b1, 2'd2, 1'b0, 32'h0, 8'h00);
    check("midrst_post_mask", rd_a, 32'h0);

    // Wide any-edge instance: exact latency, both edges of bit 31, reserved read
    do_reset();
    for (int k = 1; k <= int'(S_B) + 2; k++) begin
      step_b(2'd3, 1'b0, 32'h0, 32'h8000_0000);
      if (k == int'(S_B) + 1) check("b_rise_early", rd_b, 32'h0);
      if (k == int'(S_B) + 2) check("b_rise_cap", rd_b, 32'h8000_0000);
    end
    step_b(2'd0, 1'b0, 32'h0, 32'h8000_0000);
    check("b_data", rd_b, 32'h8000_0000);
    step_b(2'd1, 1'b0, 32'h0, 32'h8000_0000);
    check("b_rsvd", rd_b, 32'h0);
    step_b(2'd3, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    step_b(2'd3, 1'b0, 32'h0, 32'h8000_0000);
    check("b_cleared", rd_b, 32'h0);
    for (int k = 1; k <= int'(S_B) + 2; k++) begin
      step_b(2'd3, 1'b0, 32'h0, 32'h0);
      if (k == int'(S_B) + 1) check("b_fall_early", rd_b, 32'h0);
      if (k == int'(S_B) + 2) check("b_fall_cap", rd_b, 32'h8000_0000);
    end
    step_b(2'd2, 1'b1, 32'h8000_0000, 32'h0);
    step_b(2'd2, 1'b0, 32'h0, 32'h0);
    check("b_mask", rd_b, 32'h8000_0000);
    check("b_irq", {31'h0, irq_b}, 32'h1);

    // Sub-period pulses asynchronous to clk: captured at most once, never X
    do_reset();
    for (int p = 0; p < 6; p++) begin
      #($urandom_range(1, 8)) in_a = 8'h04;
      #($urandom_range(1, 8)) in_a = 8'h00;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        step_a(1'b1, 2'd3, 1'b0, 32'h0, 8'h00);
        check($sformatf("pulse%0d_noX", p), {31'h0, $isunknown(rd_a)}, 32'h0);
      end
      check($sformatf("pulse%0d_bits", p), rd_a & ~32'h04, 32'h0);
      step_a(1'b1, 2'd3, 1'b1, 32'hFF, 8'h00);
      for (int k = 0; k < 5; k++) step_a(1'b1, 2'd3, 1'b0, 32'h0, 8'h00);
      check($sformatf("pulse%0d_once", p), rd_a, 32'h0);
    end

    // Random traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  ra;
      logic        rw, rcs;
      logic [31:0] rwd;
      logic [7:0]  rin;
      ra  = 2'($urandom_range(0, 3));
      rw  = ($urandom_range(0, 3) == 0);
      rcs = ($urandom_range(0, 7) != 0);
      rwd = $urandom;
      rin = ($urandom_range(0, 3) == 0) ? 8'($urandom) : in_a;
      model_step(rcs && rw, ra, rwd, rin);
      step_a(rcs, ra, rw, rwd, rin);
      check($sformatf("rand%0d_rd", i), rd_a, m_rd);
      check($sformatf("rand%0d_irq", i), {31'h0, irq_a}, {31'h0, m_irq});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
